// File: rtl/output_requant_fifo_if.sv
// Bundles the accumulator capture side and the drained FIFO side of output_requant_fifo.
// The bench drives through master and the requant FIFO sits on slave.
interface output_requant_fifo_if #(
    parameter int ACCUMULATION_WIDTH = 32,
    parameter int IO_DATA_WIDTH      = 16,
    parameter int FIFO_DEPTH         = 8,
    parameter int FEATURE_MAP_WIDTH  = 1024,
    parameter int FEATURE_MAP_HEIGHT = 1024,
    parameter int OUTPUT_NB_CHANNELS = 64
);
    localparam int X_W   = $clog2(FEATURE_MAP_WIDTH);
    localparam int Y_W   = $clog2(FEATURE_MAP_HEIGHT);
    localparam int C_W   = $clog2(OUTPUT_NB_CHANNELS);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic signed [ACCUMULATION_WIDTH-1:0] in_data;
    logic                                 in_valid;
    logic        [X_W-1:0]                in_x;
    logic        [Y_W-1:0]                in_y;
    logic        [C_W-1:0]                in_ch;
    logic signed [IO_DATA_WIDTH-1:0]      out_data;
    logic        [X_W-1:0]                out_x;
    logic        [Y_W-1:0]                out_y;
    logic        [C_W-1:0]                out_ch;
    logic                                 out_valid;
    logic                                 out_ready;
    logic        [CNT_W-1:0]              count;
    logic                                 overflow;
    logic                                 saturated;
    logic                                 clear_flags;

    modport master (
        output in_data, in_valid, in_x, in_y, in_ch, out_ready, clear_flags,
        input  out_data, out_x, out_y, out_ch, out_valid, count, overflow, saturated
    );

    modport slave (
        input  in_data, in_valid, in_x, in_y, in_ch, out_ready, clear_flags,
        output out_data, out_x, out_y, out_ch, out_valid, count, overflow, saturated
    );
endinterface

// File: rtl/output_requant_fifo.sv
// Requantizes core accumulator words (round, saturate) and buffers them with their
// coordinates in a small FIFO drained by valid/ready; sticky flags report drops and clipping.
module output_requant_fifo #(
    parameter int ACCUMULATION_WIDTH = 32,
    parameter int IO_DATA_WIDTH      = 16,
    parameter int OUTPUT_SHIFT       = 0,
    parameter int FIFO_DEPTH         = 8,
    parameter int FEATURE_MAP_WIDTH  = 1024,
    parameter int FEATURE_MAP_HEIGHT = 1024,
    parameter int OUTPUT_NB_CHANNELS = 64
) (
    input logic                   clk,
    input logic                   arst_n_in,
    output_requant_fifo_if.slave  bus
);
    localparam int X_W     = $clog2(FEATURE_MAP_WIDTH);
    localparam int Y_W     = $clog2(FEATURE_MAP_HEIGHT);
    localparam int C_W     = $clog2(OUTPUT_NB_CHANNELS);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int EXT_W   = ACCUMULATION_WIDTH + 1;
    localparam int ENTRY_W = IO_DATA_WIDTH + X_W + Y_W + C_W;

    // Saturation bounds expressed at the extended arithmetic width.
    localparam logic signed [EXT_W-1:0] SAT_MAX =
        {{(EXT_W-IO_DATA_WIDTH+1){1'b0}}, {(IO_DATA_WIDTH-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] SAT_MIN =
        {{(EXT_W-IO_DATA_WIDTH+1){1'b1}}, {(IO_DATA_WIDTH-1){1'b0}}};

    logic signed [EXT_W-1:0]         ext_data;
    logic signed [EXT_W-1:0]         shifted;
    logic        [IO_DATA_WIDTH-1:0] requant_word;
    logic                            requant_sat;

    assign ext_data = {bus.in_data[ACCUMULATION_WIDTH-1], bus.in_data};

    generate
        if (OUTPUT_SHIFT > 0) begin : g_round
            // Adding half an LSB before the arithmetic shift rounds half toward +inf.
            localparam logic signed [EXT_W-1:0] HALF =
                {{(EXT_W-1){1'b0}}, 1'b1} << (OUTPUT_SHIFT - 1);
            assign shifted = (ext_data + HALF) >>> OUTPUT_SHIFT;
        end else begin : g_pass
            assign shifted = ext_data;
        end
    endgenerate

    always_comb begin
        requant_word = shifted[IO_DATA_WIDTH-1:0];
        requant_sat  = 1'b0;
        if (shifted > SAT_MAX) begin
            requant_word = SAT_MAX[IO_DATA_WIDTH-1:0];
            requant_sat  = 1'b1;
        end else if (shifted < SAT_MIN) begin
            requant_word = SAT_MIN[IO_DATA_WIDTH-1:0];
            requant_sat  = 1'b1;
        end
    end

    logic                     r_valid_reg;
    logic                     r_sat_reg;
    logic [ENTRY_W-1:0]       r_entry_reg;

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            r_valid_reg <= 1'b0;
            r_sat_reg   <= 1'b0;
            r_entry_reg <= '0;
        end else begin
            r_valid_reg <= bus.in_valid;
            if (bus.in_valid) begin
                r_sat_reg   <= requant_sat;
                r_entry_reg <= {requant_word, bus.in_x, bus.in_y, bus.in_ch};
            end
        end
    end

    logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg;
    logic               overflow_reg;
    logic               saturated_reg;
    logic               fifo_full;
    logic               fifo_nonempty;
    logic               push;
    logic               pop;
    logic               drop;

    assign fifo_full     = (count_reg == CNT_W'(FIFO_DEPTH));
    assign fifo_nonempty = (count_reg != '0);
    assign pop           = fifo_nonempty && bus.out_ready;
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign push          = r_valid_reg && (!fifo_full || pop);
    assign drop          = r_valid_reg && fifo_full && !pop;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= r_entry_reg;
        end
    end

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            saturated_reg <= 1'b0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
            if (drop)                 overflow_reg <= 1'b1;
            else if (bus.clear_flags) overflow_reg <= 1'b0;
            if (push && r_sat_reg)    saturated_reg <= 1'b1;
            else if (bus.clear_flags) saturated_reg <= 1'b0;
        end
    end

    logic [ENTRY_W-1:0] head_entry;

    // Head is forced to zero when empty so the outputs read 0 straight out of reset.
    assign head_entry = fifo_nonempty ? fifo_mem[rd_ptr_reg] : '0;
    assign {bus.out_data, bus.out_x, bus.out_y, bus.out_ch} = head_entry;
    assign bus.out_valid = fifo_nonempty;
    assign bus.count     = count_reg;
    assign bus.overflow  = overflow_reg;
    assign bus.saturated = saturated_reg;
endmodule

// File: doc/output_requant_fifo.md
# output_requant_fifo

Downstream stage of the convolution chip core: captures each accumulated output word with its (x, y, ch) coordinates on the cycle the core flags it valid. It rescales the word to the IO data width with rounding and saturation, and buffers it in a small FIFO. The FIFO is drained through a valid/ready handshake. The core's output has no backpressure, so this block absorbs downstream stalls and reports any loss.

## Interface
- ACCUMULATION_WIDTH, 32, width of incoming signed accumulator word
- IO_DATA_WIDTH, 16, width of outgoing signed data word
- OUTPUT_SHIFT, 0, arithmetic right-shift applied before saturation; 0..ACCUMULATION_WIDTH-1
- FIFO_DEPTH, 8, entry count; power of two, ≥ 2
- FEATURE_MAP_WIDTH, 1024, sizes the x coordinate as $clog2(FEATURE_MAP_WIDTH)
- FEATURE_MAP_HEIGHT, 1024, sizes the y coordinate as $clog2(FEATURE_MAP_HEIGHT)
- OUTPUT_NB_CHANNELS, 64, sizes the ch coordinate as $clog2(OUTPUT_NB_CHANNELS)

Ports:
- clk  in  1  single clock, rising edge
- arst_n_in  in  1  reset, asynchronous assert, active-low
- in_data  in  ACCUMULATION_WIDTH  signed accumulator word
- in_valid  in  1  in_data and coordinates valid this cycle; cannot be stalled
- in_x / in_y / in_ch  in  coord widths  coordinates of in_data
- out_data  out  IO_DATA_WIDTH  signed requantized word at FIFO head
- out_x / out_y / out_ch  out  coord widths  coordinates at FIFO head
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts the head this cycle
- count  out  $clog2(FIFO_DEPTH+1)  occupied entries
- overflow  out  1  sticky: a word was dropped
- saturated  out  1  sticky: at least one word was clipped
- clear_flags  in  1  synchronous clear of overflow and saturated

## Operation
- Stage R (requant register):
  - On in_valid, it latches the requantized word, the coordinates and the sat bit, and sets r_valid.
  - r_valid is 0 on any cycle without in_valid.
- Requant arithmetic:
  - Computed at ACCUMULATION_WIDTH+1 bits, signed.
  - If OUTPUT_SHIFT > 0: t = (in_data + 2^(OUTPUT_SHIFT-1)) >>> OUTPUT_SHIFT (round half toward +inf). Otherwise t = in_data.
  - If t > 2^(IO_DATA_WIDTH-1)-1, the result is that maximum. If t < -2^(IO_DATA_WIDTH-1), the result is that minimum. Otherwise the result is t truncated.
  - sat = 1 when clipping occurred.
- FIFO push: at the edge where r_valid = 1.
  - Full with no pop in the same cycle: the entry is dropped, overflow is set, and the pointers are unchanged.
  - Full with a pop in the same cycle: push and pop both happen; no drop, and count is unchanged.
- FIFO pop: at the edge where out_valid && out_ready. out_ready while empty has no effect.
- Pointers wrap modulo FIFO_DEPTH.
- count tracks occupancy: +1 on push only, -1 on pop only, unchanged on both or neither.
- saturated is set when an accepted entry has sat = 1. A dropped entry does not set saturated.
- clear_flags:
  - Clears both flags at the next edge.
  - If a set event occurs in the same cycle, set wins.
- out_data, out_x, out_y and out_ch show the head entry directly from storage. Their values are don't-care while out_valid = 0.

## Timing
- Reset (asynchronous, immediate):
  - Pointers, count, r_valid, overflow and saturated all go to 0.
  - out_valid = 0. out_data, out_x, out_y and out_ch = 0.
  - Storage contents are don't-care.
- A reset mid-stream discards all buffered and in-flight words. No out_valid occurs before the first post-reset push.
- Latency with the FIFO empty:
  - in_valid sampled at edge k gives r_valid high in cycle k..k+1.
  - The entry is written at edge k+1, and out_valid is high from edge k+1.
  - Result: 2 edges from sample to visible output.
- Throughput: one word per cycle in and out. With out_ready held at 1, the FIFO never exceeds 1 entry.
- out_valid must not depend combinationally on out_ready. It is derived from registered count only.

## Test plan
- Setup: OUTPUT_SHIFT=4, IO_DATA_WIDTH=16, FIFO_DEPTH=8.
  - in_data 24 (x=3, y=5, ch=7) → out_data 2, coordinates 3/5/7, out_valid two edges after sampling, saturated 0.
  - in_data -24 → out_data -1.
  - in_data 0x7FFFFFFF → out_data 32767, saturated 1.
  - in_data 0x80000000 → out_data -32768.
- out_ready=0 and 10 consecutive in_valid words 0..9 (shift 0) → count reaches 8, overflow set when word 8 arrives, words 8 and 9 dropped. Then out_ready=1 → exactly words 0..7 out in order, count returns to 0.
- FIFO full, then in_valid and out_ready asserted in the same cycle for 4 cycles → no overflow, count stays 8, and the output order is preserved across pointer wrap.
- overflow=1 and saturated=1, then clear_flags for one cycle with no simultaneous events → both flags 0. Repeat with a saturating word arriving in the clear cycle → saturated remains 1.
- arst_n_in asserted with 5 entries buffered and r_valid=1 → out_valid, count and flags are 0 immediately. After release, no output appears until a new in_valid, and that word emerges with 2-edge latency.
